big_core_kbd_controller: RTL and testbench
==========================================

Name: big_core_kbd_controller

Overview:
PS/2 keyboard receiver for the big_core. It oversamples the keyboard clock and data lines in the core_clk domain and deserialises 11-bit frames. It decodes the scan-code prefixes E0 (extended) and F0 (break), and presents make codes to the core through a data_ready/core_read_en handshake gated by scanf_en.

Parameters:
SYNC_STAGES, 2, synchroniser flops on kbd_clk and data_in_kc (minimum 2).
TIMEOUT_CYCLES, 4096, core_clk cycles without a kbd_clk falling edge mid-frame before the frame is aborted (used only with KBD_TIMEOUT_EN).

Ports:
core_clk  in  1  the single design clock; all state lives in this domain.
core_rst  in  1  reset, asynchronous, active-high.
kbd_clk  in  1  PS/2 clock from the keyboard; asynchronous, idle high; treated as data.
data_in_kc  in  1  PS/2 data; asynchronous, idle high.
scanf_en  in  1  core is waiting for input; make codes are latched for the core only while it is 1.
core_read_en  in  1  core consumes the pending code; clears data_ready.
data_out  out  8  last accepted make code.
valid  out  1  one-cycle pulse when data_out and extension update.
extension  out  1  data_out was preceded by E0.
error  out  1  one-cycle pulse on a framing or parity error.
data_ready  out  1  a code is pending for the core.

Behaviour:
- Reset (async, core_rst=1):
  - data_out=0x00; valid, extension, error, data_ready=0.
  - FSM goes to IDLE; shift register and prefix flags are cleared; synchronisers are preset to 1.
  - Reset mid-frame discards the partial frame.
- Sampling:
  - kbd_clk and data_in_kc each pass through SYNC_STAGES flops.
  - A falling edge is synchronised-previous=1 and synchronised-current=0.
  - Data is sampled from the synchronised data line in the edge-detect cycle.
- Frame: start(0), D0..D7 LSB first, odd parity, stop(1).
- FSM states and transitions:
  - IDLE: on an edge with data=0, go to DATA with bit count 0. On an edge with data=1, ignore it and stay in IDLE.
  - DATA: shift 8 bits on 8 edges, then go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: capture the stop bit, evaluate the frame, return to IDLE.
- Frame evaluation:
  - Good frame: XOR of D0..D7 and parity is 1, and stop=1.
  - Any other frame: error pulses 1 cycle, prefix flags clear, no other output changes.
- Good byte handling:
  - 0xE0: set ext_flag. No valid.
  - 0xF0: set brk_flag. No valid.
  - Other byte with brk_flag=1: break code. Both flags clear; no valid; data_ready is unchanged.
  - Other byte with brk_flag=0: make code.
    - data_out=byte, extension=ext_flag, valid pulses 1 cycle.
    - ext_flag clears.
    - If scanf_en=1 in that cycle, data_ready is set.
- Latency: valid/error is asserted exactly 1 core_clk after the cycle that detects the stop-bit falling edge.
- Handshake:
  - data_ready stays high until core_read_en=1 is sampled; it clears the next cycle.
  - A new make code arriving while data_ready=1 overwrites data_out; data_ready stays 1 (no overflow flag).
  - If a set and a clear happen in the same cycle, set wins.
- data_out and extension hold their value between valid pulses.
- A kbd_clk rising edge never changes state.

Optional Feature:
KBD_TIMEOUT_EN:
- Defined: a counter resets on every kbd_clk falling edge. In any non-IDLE state, reaching TIMEOUT_CYCLES returns the FSM to IDLE, clears the prefix flags and pulses error.
- Undefined: no counter exists; a stalled frame waits indefinitely.

Decomposition:
- Shared package big_core_kbd_pkg:
  - FSM enum t_kbd_state (IDLE, DATA, PARITY, STOP).
  - Constants KBD_EXT_CODE=8'hE0, KBD_BRK_CODE=8'hF0, KBD_FRAME_BITS=11.
- Sub-module big_core_kbd_sync: the synchroniser plus falling-edge detector. It is instantiated for kbd_clk; the data line uses the sync-only path.

Test Plan:
- Frame 0x1D (parity 1) with scanf_en=1 -> valid pulse, data_out=0x1D, extension=0, data_ready=1, error=0.
- Frames E0 then 0x75 -> valid exactly once, data_out=0x75, extension=1. A following 0x1D gives extension=0.
- Frames F0 then 0x1D -> no valid, data_out keeps its prior value. A subsequent 0x1D -> valid, data_out=0x1D.
- Frame 0x1D with parity 0, and a separate frame with stop=0 -> error pulses once each, no valid, data_ready unchanged.
- Make code with scanf_en=0 -> valid pulses, data_ready stays 0. With scanf_en=1, then core_read_en=1 -> data_ready clears next cycle.
- core_rst asserted after 5 data bits, released, then a clean 0x1D frame -> outputs are 0 during reset and 0x1D is received correctly. With KBD_TIMEOUT_EN, stopping kbd_clk after 3 bits -> error after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/big_core_kbd_pkg.sv
// Shared types and constants for the big_core PS/2 keyboard receiver.
package big_core_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } t_kbd_state;

  localparam logic [7:0]  KBD_EXT_CODE   = 8'hE0;
  localparam logic [7:0]  KBD_BRK_CODE   = 8'hF0;
  localparam int unsigned KBD_FRAME_BITS = 11;

endpackage

// File: rtl/big_core_kbd_sync.sv
// Multi-flop synchroniser with falling-edge detector for the PS/2 clock line.
module big_core_kbd_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_sr;
  logic                   prev;

  // Synchroniser chain and previous-value flop, preset to the idle-high level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr <= '1;
      prev    <= 1'b1;
    end else begin
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], din};
      prev    <= sync_sr[SYNC_STAGES-1];
    end
  end

  assign fall = prev & ~sync_sr[SYNC_STAGES-1];

endmodule

// File: rtl/big_core_kbd_controller.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix decoder and core
// handshake. Optional frame timeout enabled by defining KBD_TIMEOUT_EN.
module big_core_kbd_controller
  import big_core_kbd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic       kbd_clk,
  input  logic       data_in_kc,
  input  logic       scanf_en,
  input  logic       core_read_en,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       extension,
  output logic       error,
  output logic       data_ready
);

  t_kbd_state             state, state_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             shift, shift_n;
  logic                   par, par_n;
  logic                   ext_flag, ext_flag_n;
  logic                   brk_flag, brk_flag_n;
  logic [7:0]             data_out_n;
  logic                   extension_n, valid_n, error_n, data_ready_n;
  logic                   fall;
  logic [SYNC_STAGES-1:0] dsync;
  logic                   kbd_data;
  logic                   timeout;

  big_core_kbd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk  (core_clk),
    .rst  (core_rst),
    .din  (kbd_clk),
    .fall (fall)
  );

  // Data line synchroniser; same depth as the clock path so samples align with fall.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) dsync <= '1;
    else          dsync <= {dsync[SYNC_STAGES-2:0], data_in_kc};
  end
  assign kbd_data = dsync[SYNC_STAGES-1];

`ifdef KBD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;

  // Cycles since the last kbd_clk falling edge while a frame is in progress.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst)                    timer <= '0;
    else if (fall || state == IDLE)  timer <= '0;
    else                             timer <= timer + 1'b1;
  end
  assign timeout = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
`else
  // Without the counter TIMEOUT_CYCLES has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      data_out   <= '0;
      extension  <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par        <= par_n;
      ext_flag   <= ext_flag_n;
      brk_flag   <= brk_flag_n;
      data_out   <= data_out_n;
      extension  <= extension_n;
      valid      <= valid_n;
      error      <= error_n;
      data_ready <= data_ready_n;
    end
  end

  // Next-state, frame evaluation, prefix decode and handshake.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    par_n        = par;
    ext_flag_n   = ext_flag;
    brk_flag_n   = brk_flag;
    data_out_n   = data_out;
    extension_n  = extension;
    valid_n      = 1'b0;
    error_n      = 1'b0;
    data_ready_n = data_ready;

    // Clear first so that a same-cycle set below takes priority.
    if (core_read_en) data_ready_n = 1'b0;

    case (state)
      IDLE: begin
        if (fall && !kbd_data) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_n   = {kbd_data, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = kbd_data;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if ((^shift ^ par) && kbd_data) begin
            if (shift == KBD_EXT_CODE) begin
              ext_flag_n = 1'b1;
            end else if (shift == KBD_BRK_CODE) begin
              brk_flag_n = 1'b1;
            end else if (brk_flag) begin
              ext_flag_n = 1'b0;
              brk_flag_n = 1'b0;
            end else begin
              data_out_n  = shift;
              extension_n = ext_flag;
              valid_n     = 1'b1;
              ext_flag_n  = 1'b0;
              if (scanf_en) data_ready_n = 1'b1;
            end
          end else begin
            error_n    = 1'b1;
            ext_flag_n = 1'b0;
            brk_flag_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (timeout) begin
      state_n    = IDLE;
      ext_flag_n = 1'b0;
      brk_flag_n = 1'b0;
      error_n    = 1'b1;
    end
  end

endmodule

// File: tb/tb_big_core_kbd_controller.sv
// Directed self-checking bench for big_core_kbd_controller.
module tb_big_core_kbd_controller;

  localparam int unsigned TMO = 64;

  logic       core_clk = 1'b0;
  logic       core_rst, kbd_clk, data_in_kc, scanf_en, core_read_en;
  logic [7:0] data_out;
  logic       valid, extension, error, data_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_cnt = 0, err_cnt = 0, valid_cyc = 0, stop_cyc = 0;
  logic ready_at_valid = 1'b0;

  big_core_kbd_controller #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .core_clk     (core_clk),
    .core_rst     (core_rst),
    .kbd_clk      (kbd_clk),
    .data_in_kc   (data_in_kc),
    .scanf_en     (scanf_en),
    .core_read_en (core_read_en),
    .data_out     (data_out),
    .valid        (valid),
    .extension    (extension),
    .error        (error),
    .data_ready   (data_ready)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc++;

  // Pulse recorder sampled on the inactive edge.
  always @(negedge core_clk) begin
    if (!core_rst) begin
      if (valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        ready_at_valid = data_ready;
      end
      if (error) err_cnt++;
    end
  end

  task automatic clear_counts();
    valid_cnt = 0;
    err_cnt   = 0;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge core_clk);
      data_in_kc = f[i];
      repeat (2) @(negedge core_clk);
      kbd_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (4) @(negedge core_clk);
      kbd_clk = 1'b1;
      repeat (2) @(negedge core_clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_par, input logic stop);
    logic [10:0] f;
    f = {stop, (good_par ? ~^b : ^b), b, 1'b0};
    send_bits(f, 11);
    repeat (4) @(negedge core_clk);
  endtask

  task automatic read_pulse();
    @(negedge core_clk);
    core_read_en = 1'b1;
    @(negedge core_clk);
    core_read_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge core_clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (extension !== 1'b0) begin errors++; $display("FAIL reset_extension got=%b exp=0", extension); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got=%b exp=0", data_ready); end
  endtask

  task automatic test_make();
    clear_counts();
    scanf_en = 1'b1;
    send_byte(8'h1D, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL make_valid_cnt got=%0d exp=1", valid_cnt); end
    checks++; if (valid_cyc - stop_cyc !== 3) begin errors++; $display("FAIL make_latency got=%0d exp=3", valid_cyc - stop_cyc); end
    checks++; if (data_out !== 8'h1D) begin errors++; $display("FAIL make_data got=%h exp=1d", data_out); end
    checks++; if (extension !== 1'b0) begin errors++; $display("FAIL make_ext got=%b exp=0", extension); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL make_ready got=%b exp=1", data_ready); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL make_error got=%0d exp=0", err_cnt); end
    read_pulse();
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL make_read_clear got=%b exp=0", data_ready); end
  endtask

  task automatic test_extended();
    clear_counts();
    send_byte(8'hE0, 1'b1, 1'b1);
    send_byte(8'h75, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL ext_valid_cnt got=%0d exp=1", valid_cnt); end
    checks++; if (data_out !== 8'h75) begin errors++; $display("FAIL ext_data got=%h exp=75", data_out); end
    checks++; if (extension !== 1'b1) begin errors++; $display("FAIL ext_flag got=%b exp=1", extension); end
    send_byte(8'h1D, 1'b1, 1'b1);
    checks++; if (extension !== 1'b0) begin errors++; $display("FAIL ext_cleared got=%b exp=0", extension); end
    checks++; if (valid_cnt !== 2) begin errors++; $display("FAIL ext_valid_cnt2 got=%0d exp=2", valid_cnt); end
    read_pulse();
  endtask

  task automatic test_break();
    clear_counts();
    send_byte(8'hF0, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL brk_no_valid got=%0d exp=0", valid_cnt); end
    checks++; if (data_out !== 8'h1D) begin errors++; $display("FAIL brk_data_hold got=%h exp=1d", data_out); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL brk_ready got=%b exp=0", data_ready); end
    send_byte(8'hE0, 1'b1, 1'b1);
    send_byte(8'hF0, 1'b1, 1'b1);
    send_byte(8'h75, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL brk_ext_no_valid got=%0d exp=0", valid_cnt); end
    send_byte(8'h1D, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL brk_then_make got=%0d exp=1", valid_cnt); end
    checks++; if (extension !== 1'b0) begin errors++; $display("FAIL brk_flags_cleared got=%b exp=0", extension); end
  endtask

  task automatic test_errors();
    // data_ready is 1 here from the last make in test_break.
    clear_counts();
    send_byte(8'h1D, 1'b0, 1'b1);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL par_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL par_no_valid got=%0d exp=0", valid_cnt); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL par_ready got=%b exp=1", data_ready); end
    clear_counts();
    send_byte(8'h75, 1'b1, 1'b0);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL stop_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL stop_no_valid got=%0d exp=0", valid_cnt); end
    checks++; if (data_out !== 8'h1D) begin errors++; $display("FAIL stop_data_hold got=%h exp=1d", data_out); end
    clear_counts();
    send_byte(8'hE0, 1'b1, 1'b1);
    send_byte(8'h33, 1'b0, 1'b1);
    send_byte(8'h75, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 1 || extension !== 1'b0) begin
      errors++; $display("FAIL err_clears_prefix got=%0d/%b exp=1/0", valid_cnt, extension);
    end
    read_pulse();
  endtask

  task automatic test_handshake();
    clear_counts();
    scanf_en = 1'b0;
    send_byte(8'h75, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL noscanf_valid got=%0d exp=1", valid_cnt); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL noscanf_ready got=%b exp=0", data_ready); end
    scanf_en = 1'b1;
    send_byte(8'h1D, 1'b1, 1'b1);
    send_byte(8'h75, 1'b1, 1'b1);
    checks++; if (data_ready !== 1'b1 || data_out !== 8'h75) begin
      errors++; $display("FAIL overwrite got=%b/%h exp=1/75", data_ready, data_out);
    end
    @(negedge core_clk);
    core_read_en = 1'b1;
    @(negedge core_clk);
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL read_clear got=%b exp=0", data_ready); end
    // Read held across a make: set wins in the valid cycle, clears the next.
    send_byte(8'h1D, 1'b1, 1'b1);
    checks++; if (ready_at_valid !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", ready_at_valid); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL set_then_clear got=%b exp=0", data_ready); end
    core_read_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [10:0] f;
    f = {1'b1, 1'b1, 8'h75, 1'b0};
    send_bits(f, 6);
    @(negedge core_clk);
    core_rst = 1'b1;
    @(negedge core_clk);
    checks++; if (data_out !== 8'h00 || valid !== 1'b0 || extension !== 1'b0 || data_ready !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL midframe_rst got=%h/%b/%b/%b/%b exp=00/0/0/0/0", data_out, valid, extension, data_ready, error);
    end
    core_rst = 1'b0;
    repeat (3) @(negedge core_clk);
    clear_counts();
    send_byte(8'h1D, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 1 || data_out !== 8'h1D || err_cnt !== 0) begin
      errors++; $display("FAIL after_rst got=%0d/%h/%0d exp=1/1d/0", valid_cnt, data_out, err_cnt);
    end
  endtask

`ifdef KBD_TIMEOUT_EN
  task automatic test_timeout();
    logic [10:0] f;
    f = {1'b1, 1'b1, 8'h1D, 1'b0};
    clear_counts();
    send_bits(f, 4);
    repeat (TMO / 2) @(negedge core_clk);
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL timeout_early got=%0d exp=0", err_cnt); end
    repeat (TMO) @(negedge core_clk);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL timeout_err got=%0d exp=1", err_cnt); end
    clear_counts();
    send_byte(8'h75, 1'b1, 1'b1);
    checks++; if (valid_cnt !== 1 || data_out !== 8'h75) begin
      errors++; $display("FAIL timeout_recover got=%0d/%h exp=1/75", valid_cnt, data_out);
    end
  endtask
`endif

  initial begin
    core_rst     = 1'b1;
    kbd_clk      = 1'b1;
    data_in_kc   = 1'b1;
    scanf_en     = 1'b0;
    core_read_en = 1'b0;
    repeat (3) @(negedge core_clk);
    test_reset();
    core_rst = 1'b0;
    repeat (3) @(negedge core_clk);
    test_make();
    test_extended();
    test_break();
    test_errors();
    test_handshake();
    test_reset_midframe();
`ifdef KBD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
